// File: rtl/ysyx_22040127_ifu_pkg.sv
// rtl/ysyx_22040127_ifu_pkg.sv - shared constants and types for the instruction fetch unit
//
// Purpose : state encoding, default reset PC, address and instruction widths,
//           and small helpers used by the fetch unit.
// Ports   : none (package).
package ysyx_22040127_ifu_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          INST_W       = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  // 2-bit state encoding of the fetch FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD
  } ifu_state_e;

  // A 32-bit instruction fetch needs a word-aligned PC.
  function automatic logic pc_misaligned(input logic [1:0] pc_low);
    return |pc_low;
  endfunction

endpackage

// File: rtl/ysyx_22040127_ifu.sv
// rtl/ysyx_22040127_ifu.sv - instruction fetch unit: PC, single-outstanding fetch, decode handshake
//
// Purpose : owns the PC, issues one fetch at a time to instruction memory and
//           holds the returned word for decode; execute redirects replace the
//           PC and make any in-flight fetch stale.
// Ports   :
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        fetch request to instruction memory
//   imem_resp_valid/data             fetch response from instruction memory
//   inst_valid/ready, instruction,   held instruction and its PC toward decode
//   inst_pc
//   redirect_valid/pc                control-flow redirect from execute
//   fetch_misalign                   current PC is not word aligned
module ysyx_22040127_ifu
  import ysyx_22040127_ifu_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] instruction,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              fetch_misalign
);

  ifu_state_e        state;
  logic [XLEN-1:0]   pc;
  // Set when a redirect lands while a fetch is in flight; the response that
  // eventually returns belongs to the old path and must be thrown away.
  logic              drop;

  assign fetch_misalign = pc_misaligned(pc[1:0]);
  assign imem_req_addr  = pc;

  // A redirect in the same cycle suppresses both the request and the offer to
  // decode, so nothing from the old path leaves the unit that cycle.
  assign imem_req_valid = (state == S_REQ) && !redirect_valid && !fetch_misalign;
  assign inst_valid     = (state == S_HOLD) && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      instruction <= '0;
      inst_pc     <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          state <= S_REQ;
        end

        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (imem_req_valid && imem_req_ready) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (imem_resp_valid) begin
              // The in-flight response is consumed right here, so no drop
              // needs to be remembered.
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              instruction <= imem_resp_data;
              inst_pc     <= pc;
              state       <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // Redirect wins over a simultaneous decode handshake: the held word
          // is on the wrong path, so the PC takes the target, not PC+4.
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + XLEN'(4);
            state <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// tb/tb_ysyx_22040127_ifu.sv - self-checking bench for the instruction fetch unit
module tb_ysyx_22040127_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_misalign;

  ysyx_22040127_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_misalign  (fetch_misalign)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // memory model: one pending response, returned lat cycles after acceptance
  bit          pend = 0;
  int          pend_due = 0;
  logic [31:0] pend_data = '0;
  int          lat = 1;
  bit          fixed_word = 0;

  // reference model: flags describing what the fetch unit owes
  bit          m_idle = 1, m_out = 0, m_stale = 0, m_hold = 0;
  logic [63:0] m_pc = RST_PC, m_hpc = '0;
  logic [31:0] m_word = '0;
  bit          e_req, e_iv, e_mis;

  logic [63:0] q_addr[$];
  logic [31:0] q_word[$];
  logic [63:0] d_pc[$];
  logic [31:0] d_word[$];
  int          d_cyc[$];

  task automatic clear_logs();
    q_addr.delete(); q_word.delete(); d_pc.delete(); d_word.delete(); d_cyc.delete();
  endtask

  task automatic drive(input bit r, input bit rdy, input bit ir, input bit rv, input logic [63:0] rpc);
    rst             = r;
    imem_req_ready  = rdy && !pend;
    imem_resp_valid = pend && (cyc == pend_due);
    imem_resp_data  = imem_resp_valid ? pend_data : 32'($urandom);
    inst_ready      = ir;
    redirect_valid  = rv;
    redirect_pc     = rv ? rpc : {32'($urandom), 32'($urandom)};
    if (r) begin
      m_idle = 1; m_pc = RST_PC; m_out = 0; m_stale = 0; m_hold = 0;
    end
    #1;
    e_req = !r && !m_idle && !m_out && !m_hold && !rv && (m_pc[1:0] == 2'b00);
    e_iv  = !r && m_hold && !rv;
    e_mis = (m_pc[1:0] != 2'b00);
  endtask

  task automatic advance();
    bit resp;
    bit acc;
    resp = imem_resp_valid;
    acc  = imem_req_valid && imem_req_ready;
    if (acc) q_addr.push_back(imem_req_addr);
    if (inst_valid && inst_ready) begin
      d_pc.push_back(inst_pc); d_word.push_back(instruction); d_cyc.push_back(cyc);
    end
    if (!rst) begin
      if (m_idle) begin
        m_idle = 0;
        if (redirect_valid) m_pc = redirect_pc;
      end else if (redirect_valid) begin
        m_pc = redirect_pc;
        m_hold = 0;
        if (m_out) begin
          if (resp) begin m_out = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else if (m_out && resp) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin m_hold = 1; m_word = imem_resp_data; m_hpc = m_pc; end
      end else if (m_hold && inst_ready) begin
        m_hold = 0;
        m_pc = m_pc + 64'd4;
      end else if (e_req && imem_req_ready) begin
        m_out = 1;
      end
    end
    if (resp) pend = 0;
    if (acc) begin
      pend = 1;
      pend_due = cyc + lat;
      pend_data = fixed_word ? 32'h0000_0413 : 32'($urandom);
      q_word.push_back(pend_data);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, '0);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== 3'b000) begin
        errors++; $display("FAIL reset_valids got=%b exp=000", {imem_req_valid, inst_valid, fetch_misalign});
      end
      checks++;
      if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction got=%h exp=0", instruction); end
      checks++;
      if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", imem_req_addr, RST_PC); end
      advance();
    end
  endtask

  task automatic test_stream();
    int base = 0;
    clear_logs(); fixed_word = 1; lat = 1;
    for (int i = 0; i < 13; i++) begin
      if (i == 1) base = cyc;
      drive(i == 0, 1, 1, 0, '0);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL stream_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      advance();
    end
    checks++;
    if (d_pc.size() < 3) begin errors++; $display("FAIL stream_count got=%0d exp>=3", d_pc.size()); end
    else begin
      checks++; if (d_pc[0] !== RST_PC)         begin errors++; $display("FAIL stream_pc0 got=%h exp=%h", d_pc[0], RST_PC); end
      checks++; if (d_pc[1] !== RST_PC + 64'd4) begin errors++; $display("FAIL stream_pc1 got=%h exp=%h", d_pc[1], RST_PC + 64'd4); end
      checks++; if (d_pc[2] !== RST_PC + 64'd8) begin errors++; $display("FAIL stream_pc2 got=%h exp=%h", d_pc[2], RST_PC + 64'd8); end
      checks++; if (d_word[0] !== 32'h0000_0413) begin errors++; $display("FAIL stream_word got=%h exp=00000413", d_word[0]); end
      checks++; if (d_cyc[0] - base != 3) begin errors++; $display("FAIL stream_first got=%0d exp=3", d_cyc[0] - base); end
      checks++; if (d_cyc[1] - d_cyc[0] != 3) begin errors++; $display("FAIL stream_gap1 got=%0d exp=3", d_cyc[1] - d_cyc[0]); end
      checks++; if (d_cyc[2] - d_cyc[1] != 3) begin errors++; $display("FAIL stream_gap2 got=%0d exp=3", d_cyc[2] - d_cyc[1]); end
    end
    fixed_word = 0;
  endtask

  task automatic test_hold_stall();
    int base = 0;
    clear_logs(); lat = 1;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) base = cyc;
      drive(i == 0, 1, i >= 9, 0, '0);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL stall_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      if (e_iv) begin
        checks++;
        if ({instruction, inst_pc} !== {m_word, m_hpc}) begin
          errors++; $display("FAIL stall_hold i=%0d got=%h/%h exp=%h/%h", i, instruction, inst_pc, m_word, m_hpc);
        end
      end
      advance();
    end
    checks++;
    if (d_cyc.size() < 1 || q_addr.size() < 2) begin
      errors++; $display("FAIL stall_count got=%0d/%0d exp>=1/2", d_cyc.size(), q_addr.size());
    end else begin
      checks++; if (d_cyc[0] - base != 8) begin errors++; $display("FAIL stall_release got=%0d exp=8", d_cyc[0] - base); end
      checks++; if (d_word[0] !== q_word[0]) begin errors++; $display("FAIL stall_word got=%h exp=%h", d_word[0], q_word[0]); end
      checks++; if (q_addr[1] !== RST_PC + 64'd4) begin errors++; $display("FAIL stall_next got=%h exp=%h", q_addr[1], RST_PC + 64'd4); end
    end
  endtask

  task automatic test_redirect_wait();
    clear_logs(); lat = 3;
    for (int i = 0; i < 14; i++) begin
      drive(i == 0, 1, 1, i == 3, 64'h8000_1000);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL rwait_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      if (e_iv) begin
        checks++;
        if ({instruction, inst_pc} !== {m_word, m_hpc}) begin
          errors++; $display("FAIL rwait_hold i=%0d got=%h/%h exp=%h/%h", i, instruction, inst_pc, m_word, m_hpc);
        end
      end
      advance();
    end
    checks++;
    if (q_addr.size() < 2 || d_pc.size() < 1) begin
      errors++; $display("FAIL rwait_count got=%0d/%0d exp>=2/1", q_addr.size(), d_pc.size());
    end else begin
      checks++; if (q_addr[1] !== 64'h8000_1000) begin errors++; $display("FAIL rwait_addr got=%h exp=0000000080001000", q_addr[1]); end
      checks++; if (d_pc[0] !== 64'h8000_1000) begin errors++; $display("FAIL rwait_pc got=%h exp=0000000080001000", d_pc[0]); end
      checks++; if (d_word[0] !== q_word[1]) begin errors++; $display("FAIL rwait_word got=%h exp=%h", d_word[0], q_word[1]); end
    end
  endtask

  task automatic test_redirect_hold();
    clear_logs(); lat = 1;
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, 1, i >= 4, i == 4, 64'h8000_0100);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL rhold_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      advance();
    end
    checks++;
    if (q_addr.size() < 2 || d_pc.size() < 1) begin
      errors++; $display("FAIL rhold_count got=%0d/%0d exp>=2/1", q_addr.size(), d_pc.size());
    end else begin
      checks++; if (q_addr[1] !== 64'h8000_0100) begin errors++; $display("FAIL rhold_addr got=%h exp=0000000080000100", q_addr[1]); end
      checks++; if (d_pc[0] !== 64'h8000_0100) begin errors++; $display("FAIL rhold_pc got=%h exp=0000000080000100", d_pc[0]); end
    end
  endtask

  task automatic test_misalign();
    int mis_cycles = 0;
    clear_logs(); lat = 1;
    for (int i = 0; i < 13; i++) begin
      drive(i == 0, 1, 1, (i == 2) || (i == 7), (i == 2) ? 64'h8000_0102 : 64'h8000_0200);
      if (fetch_misalign) mis_cycles++;
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL mis_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      advance();
    end
    checks++; if (mis_cycles != 5) begin errors++; $display("FAIL mis_cycles got=%0d exp=5", mis_cycles); end
    checks++;
    if (q_addr.size() < 1) begin errors++; $display("FAIL mis_count got=0 exp>=1"); end
    else begin
      checks++; if (q_addr[0] !== 64'h8000_0200) begin errors++; $display("FAIL mis_resume got=%h exp=0000000080000200", q_addr[0]); end
    end
  endtask

  task automatic test_reset_wait();
    clear_logs(); lat = 3;
    for (int i = 0; i < 14; i++) begin
      drive((i == 0) || (i == 3), 1, 1, 0, '0);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL rstw_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      advance();
    end
    checks++;
    if (q_addr.size() < 2 || d_pc.size() < 1) begin
      errors++; $display("FAIL rstw_count got=%0d/%0d exp>=2/1", q_addr.size(), d_pc.size());
    end else begin
      checks++; if (q_addr[1] !== RST_PC) begin errors++; $display("FAIL rstw_addr got=%h exp=%h", q_addr[1], RST_PC); end
      checks++; if (d_pc[0] !== RST_PC) begin errors++; $display("FAIL rstw_pc got=%h exp=%h", d_pc[0], RST_PC); end
      checks++; if (d_word[0] !== q_word[1]) begin errors++; $display("FAIL rstw_word got=%h exp=%h", d_word[0], q_word[1]); end
    end
  endtask

  task automatic test_wrap();
    clear_logs(); lat = 1;
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, 1, 1, i == 2, 64'hFFFF_FFFF_FFFF_FFFC);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL wrap_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      advance();
    end
    checks++;
    if (q_addr.size() < 2) begin errors++; $display("FAIL wrap_count got=%0d exp>=2", q_addr.size()); end
    else begin
      checks++; if (q_addr[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_first got=%h exp=fffffffffffffffc", q_addr[0]); end
      checks++; if (q_addr[1] !== 64'h0) begin errors++; $display("FAIL wrap_next got=%h exp=0", q_addr[1]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    bit r, rv;
    clear_logs();
    for (int i = 0; i < 500; i++) begin
      lat = $urandom_range(1, 3);
      r   = (i == 0) || ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       tgt = 64'h8000_0000 + {54'd0, 8'($urandom), 2'b10};
        1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
        default: tgt = 64'h8000_0000 + {54'd0, 8'($urandom), 2'b00};
      endcase
      drive(r, $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, rv, tgt);
      checks++;
      if ({imem_req_valid, inst_valid, fetch_misalign} !== {e_req, e_iv, e_mis}) begin
        errors++; $display("FAIL rand_ctl i=%0d got=%b exp=%b", i, {imem_req_valid, inst_valid, fetch_misalign}, {e_req, e_iv, e_mis});
      end
      checks++;
      if (imem_req_addr !== m_pc) begin errors++; $display("FAIL rand_addr i=%0d got=%h exp=%h", i, imem_req_addr, m_pc); end
      if (e_iv) begin
        checks++;
        if ({instruction, inst_pc} !== {m_word, m_hpc}) begin
          errors++; $display("FAIL rand_hold i=%0d got=%h/%h exp=%h/%h", i, instruction, inst_pc, m_word, m_hpc);
        end
      end
      advance();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_reset_wait();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
